// File: rtl/lcd_timing_sched_if.sv
// Panel-side signal bundle for the LCD frame scheduler.
// The controller drives en; the scheduler drives everything else.
interface lcd_timing_sched_if;
  logic       en;
  logic [1:0] state;
  logic       DE_clk;
  logic       hsync_n;
  logic       vsync_n;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       fetch_req;
  logic [8:0] fetch_x;
  logic [8:0] fetch_y;
  logic       frame_start;

  modport master (
    output en,
    input  state, DE_clk, hsync_n, vsync_n, pix_x, pix_y,
    input  fetch_req, fetch_x, fetch_y, frame_start
  );

  modport slave (
    input  en,
    output state, DE_clk, hsync_n, vsync_n, pix_x, pix_y,
    output fetch_req, fetch_x, fetch_y, frame_start
  );
endinterface

// File: rtl/lcd_timing_sched.sv
// LCD frame scheduler: panel power-up sequencing, H/V raster, sync/DE generation
// and a pixel-fetch strobe that leads DE. Start/stop only on frame boundaries.
module lcd_timing_sched #(
  parameter int unsigned H_TOTAL     = 525,
  parameter int unsigned H_ACT_START = 45,
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned HSYNC_W     = 41,
  parameter int unsigned V_TOTAL     = 288,
  parameter int unsigned V_ACT_START = 16,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned VSYNC_W     = 10,
  parameter int unsigned PWR_DLY     = 1024,
  parameter int unsigned PREFETCH    = 2
) (
  input logic               Clk,
  input logic               Rst,
  lcd_timing_sched_if.slave bus
);
  typedef enum logic [1:0] {StIdle = 2'd0, StPwrUp = 2'd1, StRun = 2'd2, StDrain = 2'd3} state_e;

  localparam int unsigned PwrW = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam logic [PwrW-1:0] PwrLast = PwrW'(PWR_DLY - 1);
  localparam logic [9:0] HLast  = 10'(H_TOTAL - 1);
  localparam logic [8:0] VLast  = 9'(V_TOTAL - 1);
  localparam logic [9:0] HActLo = 10'(H_ACT_START);
  localparam logic [9:0] HActHi = 10'(H_ACT_START + H_ACTIVE - 1);
  // Fetch window is the active window shifted PREFETCH clocks earlier on the same line.
  localparam logic [9:0] FetLo  = 10'(H_ACT_START - PREFETCH);
  localparam logic [9:0] FetHi  = 10'(H_ACT_START + H_ACTIVE - 1 - PREFETCH);
  localparam logic [9:0] HSyncW = 10'(HSYNC_W);
  localparam logic [8:0] VActLo = 9'(V_ACT_START);
  localparam logic [8:0] VActHi = 9'(V_ACT_START + V_ACTIVE - 1);
  localparam logic [8:0] VSyncW = 9'(VSYNC_W);

  state_e          state_q, state_d;
  logic [9:0]      h_q, h_d;
  logic [8:0]      v_q, v_d;
  logic [PwrW-1:0] pwr_q, pwr_d;

  logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d, fr_q, fr_d, fs_q, fs_d;
  logic [8:0] px_q, px_d, py_q, py_d, fx_q, fx_d, fy_q, fy_d;

  logic running, h_wrap, v_wrap, v_act;

  assign running = (state_q == StRun) || (state_q == StDrain);
  assign h_wrap  = (h_q == HLast);
  assign v_wrap  = (v_q == VLast);
  assign v_act   = (v_q >= VActLo) && (v_q <= VActHi);

  always_comb begin
    state_d = state_q;
    pwr_d   = pwr_q;
    h_d     = h_q;
    v_d     = v_q;
    if (running) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 9'd1;
    end
    unique case (state_q)
      StIdle: begin
        h_d   = '0;
        v_d   = '0;
        pwr_d = '0;
        if (bus.en) state_d = StPwrUp;
      end
      StPwrUp: begin
        pwr_d = pwr_q + 1'b1;
        if (!bus.en) begin
          state_d = StIdle;
          pwr_d   = '0;
        end else if (pwr_q == PwrLast) begin
          state_d = StRun;
          h_d     = '0;
          v_d     = '0;
        end
      end
      StRun: if (!bus.en) state_d = StDrain;
      StDrain: begin
        // Re-enable wins over frame end so a restarted frame follows with no gap.
        if (bus.en)                state_d = StRun;
        else if (h_wrap && v_wrap) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    de_d = 1'b0;
    hs_d = 1'b1;
    vs_d = 1'b1;
    fr_d = 1'b0;
    fs_d = 1'b0;
    px_d = '0;
    py_d = '0;
    fx_d = '0;
    fy_d = '0;
    if (running) begin
      hs_d = (h_q >= HSyncW);
      vs_d = (v_q >= VSyncW);
      fs_d = (h_q == '0) && (v_q == '0);
      if (v_act && (h_q >= HActLo) && (h_q <= HActHi)) begin
        de_d = 1'b1;
        px_d = 9'(h_q - HActLo);
        py_d = v_q - VActLo;
      end
      if (v_act && (h_q >= FetLo) && (h_q <= FetHi)) begin
        fr_d = 1'b1;
        fx_d = 9'(h_q - FetLo);
        fy_d = v_q - VActLo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      pwr_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fr_q    <= 1'b0;
      fs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pwr_q   <= pwr_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fr_q    <= fr_d;
      fs_q    <= fs_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.DE_clk      = de_q;
  assign bus.hsync_n     = hs_q;
  assign bus.vsync_n     = vs_q;
  assign bus.pix_x       = px_q;
  assign bus.pix_y       = py_q;
  assign bus.fetch_req   = fr_q;
  assign bus.fetch_x     = fx_q;
  assign bus.fetch_y     = fy_q;
  assign bus.frame_start = fs_q;
endmodule
